// File: rtl/ni_flit_serializer_pkg.sv
// Shared constants for the NI flit serializer: default widths, flit type codes, FSM state codes.
package ni_flit_serializer_pkg;

    localparam int DEF_FLIT_WD   = 32;
    localparam int DEF_MAX_FLITS = 8;
    localparam int DEF_LEN_WD    = 3;
    localparam int DEF_BUF_DEPTH = 2;

    localparam logic [1:0] FT_BODY     = 2'b00;
    localparam logic [1:0] FT_HEAD     = 2'b01;
    localparam logic [1:0] FT_TAIL     = 2'b10;
    localparam logic [1:0] FT_HEADTAIL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    // first = flit index 0, last = flit index equals packet length
    function automatic logic [1:0] flit_type_of(input logic first, input logic last);
        logic [1:0] ft;
        ft = FT_BODY;
        if (first && last)
            ft = FT_HEADTAIL;
        else if (first)
            ft = FT_HEAD;
        else if (last)
            ft = FT_TAIL;
        return ft;
    endfunction

endpackage

// File: rtl/ni_flit_serializer_buffer.sv
// Register FIFO of {len,data} packet entries; exposes head and the entry behind it.
// Writes complete in one cycle; push ignored when full, pop ignored when empty, no bypass.
module ni_pkt_buffer
    import ni_flit_serializer_pkg::*;
#(
    parameter int ENT_WD = DEF_LEN_WD + DEF_FLIT_WD * DEF_MAX_FLITS,
    parameter int DEPTH  = DEF_BUF_DEPTH,
    parameter int OCC_WD = $clog2(DEPTH) + 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ENT_WD-1:0] push_entry,
    input  logic              pop,
    output logic [ENT_WD-1:0] head_entry,
    output logic [ENT_WD-1:0] next_entry,
    output logic              full,
    output logic              empty,
    output logic [OCC_WD-1:0] occupancy
);

    localparam int PTR_WD = $clog2(DEPTH);

    logic [ENT_WD-1:0] mem [DEPTH];
    logic [PTR_WD-1:0] wr_ptr;
    logic [PTR_WD-1:0] rd_ptr;
    logic [PTR_WD-1:0] rd_next;
    logic              do_push;
    logic              do_pop;

    assign full       = (occupancy == OCC_WD'(DEPTH));
    assign empty      = (occupancy == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_next    = rd_ptr + 1'b1;
    assign head_entry = mem[rd_ptr];
    assign next_entry = mem[rd_next];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_next;
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/ni_flit_serializer.sv
// Buffers whole packets and emits them one flit per network beat toward the switch.
// First flit two cycles after accept; holds its flit while flit_stall or no beat; pkt_ready drops when buffer full.
module ni_flit_serializer
    import ni_flit_serializer_pkg::*;
#(
    parameter int FLIT_WD   = DEF_FLIT_WD,
    parameter int MAX_FLITS = DEF_MAX_FLITS,
    parameter int LEN_WD    = DEF_LEN_WD,
    parameter int PKT_WD    = FLIT_WD * MAX_FLITS,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [PKT_WD-1:0]  pkt_data,
    input  logic [LEN_WD-1:0]  pkt_len,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    input  logic               beat,
    output logic               sync_enable,
    output logic [FLIT_WD-1:0] flit_out,
    output logic [1:0]         flit_type,
    output logic               flit_valid,
    input  logic               flit_stall
);

    localparam int ENT_WD = LEN_WD + PKT_WD;
    localparam int OCC_WD = $clog2(BUF_DEPTH) + 1;

    logic [ENT_WD-1:0]  head_entry;
    logic [ENT_WD-1:0]  next_entry;
    logic               buf_full;
    logic               buf_empty;
    logic [OCC_WD-1:0]  occupancy;

    logic               push;
    logic               pop;
    logic               consume;
    logic               at_last;
    logic               has_next;

    logic [1:0]         state;
    logic [PKT_WD-1:0]  shift_reg;
    logic [LEN_WD-1:0]  cur_len;
    logic [LEN_WD-1:0]  idx;
    logic               valid_q;

    assign pkt_ready = !buf_full;
    assign push      = pkt_valid && pkt_ready;
    assign consume   = valid_q && beat && !flit_stall;
    assign at_last   = (idx == cur_len);
    assign pop       = consume && at_last;
    // The in-flight packet still occupies its entry, so a successor exists only at occupancy >= 2.
    assign has_next  = (occupancy >= OCC_WD'(2));

    ni_pkt_buffer #(
        .ENT_WD (ENT_WD),
        .DEPTH  (BUF_DEPTH),
        .OCC_WD (OCC_WD)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ({pkt_len, pkt_data}),
        .pop        (pop),
        .head_entry (head_entry),
        .next_entry (next_entry),
        .full       (buf_full),
        .empty      (buf_empty),
        .occupancy  (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            valid_q   <= 1'b0;
            shift_reg <= '0;
            cur_len   <= '0;
            idx       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!buf_empty) begin
                        shift_reg <= head_entry[PKT_WD-1:0];
                        cur_len   <= head_entry[ENT_WD-1:PKT_WD];
                        idx       <= '0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    valid_q <= 1'b1;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (consume) begin
                        if (!at_last) begin
                            shift_reg <= shift_reg >> FLIT_WD;
                            idx       <= idx + 1'b1;
                        end else if (has_next) begin
                            shift_reg <= next_entry[PKT_WD-1:0];
                            cur_len   <= next_entry[ENT_WD-1:PKT_WD];
                            idx       <= '0;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign flit_valid  = valid_q;
    assign sync_enable = valid_q;
    assign flit_out    = valid_q ? shift_reg[FLIT_WD-1:0] : '0;
    assign flit_type   = valid_q ? flit_type_of(idx == '0, at_last) : FT_BODY;

endmodule

// File: tb/tb_ni_flit_serializer.sv
// Directed bench for ni_flit_serializer with a packet/flit queue model checked every cycle.
module tb_ni_flit_serializer;

    localparam int FW = 32;
    localparam int MF = 8;
    localparam int LW = 3;
    localparam int PW = FW * MF;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pkt_data;
    logic [LW-1:0] pkt_len;
    logic          pkt_valid;
    logic          pkt_ready;
    logic          beat;
    logic          sync_enable;
    logic [FW-1:0] flit_out;
    logic [1:0]    flit_type;
    logic          flit_valid;
    logic          flit_stall;

    int n_tests = 0;
    int n_fail  = 0;
    int beat_div = 1;
    int cyc = 0;

    ni_flit_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_data    (pkt_data),
        .pkt_len     (pkt_len),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .beat        (beat),
        .sync_enable (sync_enable),
        .flit_out    (flit_out),
        .flit_type   (flit_type),
        .flit_valid  (flit_valid),
        .flit_stall  (flit_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] mk(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                                         input logic [FW-1:0] f2, input logic [FW-1:0] f3);
        return {{(PW - 4 * FW){1'b0}}, f3, f2, f1, f0};
    endfunction

    // Beat source: every cycle when beat_div<=1, else one beat every beat_div cycles.
    initial begin
        beat = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            beat = (beat_div <= 1) ? 1'b1 : ((cyc % beat_div) == 0);
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [FW-1:0] d;
        logic [1:0]    t;
    } fl_t;

    fl_t           exp_q[$];
    int            occ = 0;
    bit            rst_seen = 1'b0;
    bit            prev_hold = 1'b0;
    logic [FW-1:0] prev_out;
    logic [1:0]    prev_type;

    always @(posedge clk) if (!rst) rst_seen = 1'b1;

    initial begin : monitor
        fl_t f;
        bit  consumed;
        bit  can_push;
        forever begin
            sample_pt();
            if (rst_seen) begin
                exp_q.delete();
                occ       = 0;
                prev_hold = 1'b0;
                rst_seen  = 1'b0;
            end
            if (rst) begin
                can_push = pkt_valid && (occ < BD);
                consumed = flit_valid && beat && !flit_stall;
                chk("m_sync_enable", sync_enable, flit_valid);
                chk("m_pkt_ready", pkt_ready, occ < BD);
                if (prev_hold) begin
                    chk("m_hold_out", flit_out, prev_out);
                    chk("m_hold_type", flit_type, prev_type);
                end
                if (flit_valid) begin
                    chk("m_flit_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        chk("m_flit_out", flit_out, exp_q[0].d);
                        chk("m_flit_type", flit_type, exp_q[0].t);
                    end
                end
                if (consumed && exp_q.size() > 0) begin
                    f = exp_q.pop_front();
                    if (f.t[1]) occ--;
                end
                if (can_push) begin
                    for (int k = 0; k <= int'(pkt_len); k++) begin
                        f.d = pkt_data[k*FW +: FW];
                        f.t = (pkt_len == 0) ? 2'b11 :
                              (k == 0) ? 2'b01 :
                              (k == int'(pkt_len)) ? 2'b10 : 2'b00;
                        exp_q.push_back(f);
                    end
                    occ++;
                end
                prev_hold = flit_valid && !consumed;
                prev_out  = flit_out;
                prev_type = flit_type;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pkt(input logic [LW-1:0] len, input logic [PW-1:0] d);
        bit acc = 1'b0;
        pkt_len   = len;
        pkt_data  = d;
        pkt_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            sample_pt();
            acc = pkt_ready;
            tick();
        end
        pkt_valid = 1'b0;
        chk("send_accepted", acc, 1);
    endtask

    task automatic wait_valid(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            sample_pt();
            if (flit_valid) got = 1'b1;
            else tick();
        end
        chk(name, got, 1);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            sample_pt();
            if (!flit_valid && exp_q.size() == 0) done = 1'b1;
            else tick();
        end
        chk(name, done, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        logic [1:0]    t3_types [4];
        logic [FW-1:0] t3_data  [4];
        int held;

        rst = 1'b0; pkt_valid = 1'b0; pkt_data = '0; pkt_len = '0; flit_stall = 1'b0;
        repeat (2) tick();
        rst = 1'b1;

        // Test 1: reset state, then 3-flit packet with latency pinned
        sample_pt();
        chk("t1_rst_flit_valid", flit_valid, 0);
        chk("t1_rst_flit_out", flit_out, 0);
        chk("t1_rst_flit_type", flit_type, 0);
        chk("t1_rst_pkt_ready", pkt_ready, 1);
        chk("t1_rst_sync_enable", sync_enable, 0);
        tick();
        send_pkt(3'd2, mk(32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'h0));
        sample_pt(); chk("t1_valid_after_N", flit_valid, 0);
        tick(); sample_pt(); chk("t1_valid_after_N1", flit_valid, 0);
        tick(); sample_pt(); chk("t1_valid_after_N2", flit_valid, 1);
        chk("t1_flitA", flit_out, 32'hA000_0001); chk("t1_typeA", flit_type, 2'b01);
        tick(); sample_pt();
        chk("t1_flitB", flit_out, 32'hB000_0002); chk("t1_typeB", flit_type, 2'b00);
        tick(); sample_pt();
        chk("t1_flitC", flit_out, 32'hC000_0003); chk("t1_typeC", flit_type, 2'b10);
        tick(); sample_pt(); chk("t1_valid_end", flit_valid, 0);
        tick();

        // Test 2: single flit with a beat every 4th cycle
        beat_div = 4;
        send_pkt(3'd0, mk(32'hD000_0044, 32'h0, 32'h0, 32'h0));
        wait_valid("t2_wait_valid");
        chk("t2_type", flit_type, 2'b11);
        chk("t2_flit", flit_out, 32'hD000_0044);
        chk("t2_sync_enable", sync_enable, 1);
        held = 0;
        while (flit_valid && held < 20) begin
            held++;
            tick();
            sample_pt();
        end
        chk("t2_held_range", (held >= 1) && (held <= 4), 1);
        chk("t2_sync_enable_off", sync_enable, 0);
        tick();
        beat_div = 1;
        drain("t2_drain");

        // Test 3: two 2-flit packets back to back, no bubble
        send_pkt(3'd1, mk(32'h3A00_0000, 32'h3A00_0001, 32'h0, 32'h0));
        send_pkt(3'd1, mk(32'h3B00_0000, 32'h3B00_0001, 32'h0, 32'h0));
        t3_types = '{2'b01, 2'b10, 2'b01, 2'b10};
        t3_data  = '{32'h3A00_0000, 32'h3A00_0001, 32'h3B00_0000, 32'h3B00_0001};
        wait_valid("t3_wait_valid");
        for (int k = 0; k < 4; k++) begin
            chk("t3_valid", flit_valid, 1);
            chk("t3_type", flit_type, t3_types[k]);
            chk("t3_flit", flit_out, t3_data[k]);
            tick();
            sample_pt();
        end
        chk("t3_valid_end", flit_valid, 0);
        tick();

        // Test 4: buffer fills while the first packet is stalled
        flit_stall = 1'b1;
        send_pkt(3'd0, mk(32'h4000_0001, 32'h0, 32'h0, 32'h0));
        send_pkt(3'd0, mk(32'h4000_0002, 32'h0, 32'h0, 32'h0));
        pkt_len = 3'd0; pkt_data = mk(32'h4000_0003, 32'h0, 32'h0, 32'h0); pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_pt();
            chk("t4_ready_full", pkt_ready, 0);
            tick();
        end
        flit_stall = 1'b0;
        sample_pt();
        chk("t4_ready_before_pop", pkt_ready, 0);
        chk("t4_flit_first", flit_out, 32'h4000_0001);
        tick();
        sample_pt();
        chk("t4_ready_after_pop", pkt_ready, 1);
        chk("t4_flit_second", flit_out, 32'h4000_0002);
        tick();
        pkt_valid = 1'b0;
        drain("t4_drain");

        // Test 5: stall across 3 beats mid-packet
        send_pkt(3'd3, mk(32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003));
        wait_valid("t5_wait_valid");
        chk("t5_flit0", flit_out, 32'h5000_0000);
        tick();
        flit_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_pt();
            chk("t5_stall_flit", flit_out, 32'h5000_0001);
            chk("t5_stall_type", flit_type, 2'b00);
            tick();
        end
        flit_stall = 1'b0;
        sample_pt(); chk("t5_release_flit", flit_out, 32'h5000_0001);
        tick(); sample_pt(); chk("t5_flit2", flit_out, 32'h5000_0002);
        tick(); sample_pt(); chk("t5_flit3", flit_out, 32'h5000_0003);
        chk("t5_type3", flit_type, 2'b10);
        tick(); sample_pt(); chk("t5_valid_end", flit_valid, 0);
        tick();

        // Test 6: reset during flit 2 of 4, with a second packet buffered
        send_pkt(3'd3, mk(32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003));
        send_pkt(3'd1, mk(32'h6F00_0000, 32'h6F00_0001, 32'h0, 32'h0));
        wait_valid("t6_wait_valid");
        tick();
        rst = 1'b0;
        sample_pt();
        chk("t6_flit1_before_rst", flit_out, 32'h6000_0001);
        tick();
        rst = 1'b1;
        sample_pt();
        chk("t6_rst_valid", flit_valid, 0);
        chk("t6_rst_ready", pkt_ready, 1);
        chk("t6_rst_flit_out", flit_out, 0);
        chk("t6_rst_flit_type", flit_type, 0);
        repeat (4) begin
            tick();
            sample_pt();
            chk("t6_buffer_empty", flit_valid, 0);
        end
        tick();
        send_pkt(3'd1, mk(32'h6A00_0000, 32'h6A00_0001, 32'h0, 32'h0));
        wait_valid("t6_wait_new");
        chk("t6_new_type", flit_type, 2'b01);
        chk("t6_new_flit", flit_out, 32'h6A00_0000);
        tick();
        drain("t6_drain");

        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_occupancy", occ, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
